// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default parameter values for the pipeline hazard sequencer.
// State encodings are fixed so they stay compatible with the original header.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } ctrlState_t;

  localparam int unsigned DEF_BOOT_CYCLES = 2;
  localparam int unsigned DEF_STALL_LIMIT = 64;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter used for the hazard performance statistics.
// The counter holds at all-ones once it gets there; it never wraps back to zero.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: merges stalls, redirects and data-memory waits
// into per-stage enables/flushes, with boot hold, stall watchdog and counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_lw,
  input  logic             stall_beq,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if2id_write,
  output logic             if2id_flush,
  output logic             id2ex_flush,
  output logic             pipe_freeze,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned WD_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(STALL_LIMIT);
  localparam logic [WD_W-1:0]   WD_TRIGGER = WD_W'(STALL_LIMIT - 1);

  ctrlState_t        state;
  ctrlState_t        curState;
  logic [BOOT_W-1:0] bootCnt;
  logic [WD_W-1:0]   wdCnt;
  logic              memWait;
  logic              stallCase;
  logic              redirCase;

  // Reset forces the BOOT decode so the reset cycle itself drives BOOT outputs.
  assign curState = rst ? BOOT : state;

  always_comb begin
    memWait     = 1'b0;
    stallCase   = 1'b0;
    redirCase   = 1'b0;
    pc_write    = 1'b0;
    if2id_write = 1'b0;
    if2id_flush = 1'b0;
    id2ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    case (curState)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          memWait = 1'b1;
        end else if (stall_lw || stall_beq) begin
          stallCase   = 1'b1;
          id2ex_flush = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if2id_write = 1'b1;
          if (branch_taken || jump) begin
            redirCase   = 1'b1;
            if2id_flush = 1'b1;
          end
        end
      end
      FREEZE: begin
        if (!dmem_ready) begin
          memWait = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if2id_write = 1'b1;
        end
      end
      default: begin
        if2id_flush = 1'b1;
        id2ex_flush = 1'b1;
      end
    endcase
    pipe_freeze = memWait;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      bootCnt    <= '0;
      wdCnt      <= '0;
      hazard_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (bootCnt == BOOT_LAST) begin
            state   <= RUN;
            bootCnt <= '0;
          end else begin
            bootCnt <= bootCnt + BOOT_W'(1);
          end
        end
        RUN:     if (memWait) state <= FREEZE;
        FREEZE:  if (dmem_ready) state <= RUN;
        default: state <= BOOT;
      endcase
      // Flag is raised on the same edge that brings the run length to the limit.
      if (stallCase) begin
        if (wdCnt != WD_LIMIT) wdCnt <= wdCnt + WD_W'(1);
        if (wdCnt >= WD_TRIGGER) hazard_err <= 1'b1;
      end else begin
        wdCnt <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk(clk), .rst(rst), .inc(stallCase), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk(clk), .rst(rst), .inc(redirCase), .count(flush_cnt)
  );

  sat_counter #(.W(CNT_W)) uFreezeCnt (
    .clk(clk), .rst(rst), .inc(memWait), .count(freeze_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance plus a 4-bit counter
// instance sharing the same stimulus for the saturation checks.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, stallLw, stallBeq, branchTaken, jump, dmemReq, dmemReady;
  logic pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze, hazardErr;
  logic [15:0] stallCnt, flushCnt, freezeCnt;
  logic pcWrite4, ifIdWrite4, ifIdFlush4, idExFlush4, pipeFreeze4, hazardErr4;
  logic [3:0] stallCnt4, flushCnt4, freezeCnt4;
  logic [4:0] ctl;

  int unsigned assertions = 0;
  int unsigned failures   = 0;

  always #5 clk = ~clk;

  assign ctl = {pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze};

  pipe_hazard_ctrl #(.BOOT_CYCLES(2), .STALL_LIMIT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_lw(stallLw), .stall_beq(stallBeq),
    .branch_taken(branchTaken), .jump(jump), .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .pc_write(pcWrite), .if2id_write(ifIdWrite), .if2id_flush(ifIdFlush),
    .id2ex_flush(idExFlush), .pipe_freeze(pipeFreeze), .hazard_err(hazardErr),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt), .freeze_cnt(freezeCnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_lw(stallLw), .stall_beq(stallBeq),
    .branch_taken(branchTaken), .jump(jump), .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .pc_write(pcWrite4), .if2id_write(ifIdWrite4), .if2id_flush(ifIdFlush4),
    .id2ex_flush(idExFlush4), .pipe_freeze(pipeFreeze4), .hazard_err(hazardErr4),
    .stall_cnt(stallCnt4), .flush_cnt(flushCnt4), .freeze_cnt(freezeCnt4)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setIdle();
    stallLw = 0; stallBeq = 0; branchTaken = 0; jump = 0; dmemReq = 0; dmemReady = 0;
    #1;
  endtask

  task automatic resetAndBoot();
    rst = 1; setIdle();
    tick();
    rst = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1; setIdle();
    assertions++;
    if (ctl !== 5'b00110) begin
      failures++; $display("FAIL reset_cycle_ctl: got %b expected 00110", ctl);
    end
    tick();
    rst = 0; #1;
    assertions++;
    if (stallCnt !== 16'd0 || flushCnt !== 16'd0 || freezeCnt !== 16'd0 || hazardErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: stall=%0d flush=%0d freeze=%0d err=%b expected 0 0 0 0",
               stallCnt, flushCnt, freezeCnt, hazardErr);
    end
  endtask

  task automatic test_boot();
    for (int i = 0; i < 2; i++) begin
      assertions++;
      if (ctl !== 5'b00110) begin
        failures++; $display("FAIL boot_cycle%0d_ctl: got %b expected 00110", i + 1, ctl);
      end
      tick();
    end
    assertions++;
    if (ctl !== 5'b11000) begin
      failures++; $display("FAIL boot_run_ctl: got %b expected 11000", ctl);
    end
  endtask

  task automatic test_load_use();
    resetAndBoot();
    stallLw = 1; #1;
    assertions++;
    if (ctl !== 5'b00010) begin
      failures++; $display("FAIL load_use_ctl: got %b expected 00010", ctl);
    end
    tick();
    stallLw = 0; #1;
    assertions++;
    if (ctl !== 5'b11000) begin
      failures++; $display("FAIL load_use_after_ctl: got %b expected 11000", ctl);
    end
    assertions++;
    if (stallCnt !== 16'd1) begin
      failures++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stallCnt);
    end
  endtask

  task automatic test_stall_branch();
    resetAndBoot();
    stallBeq = 1; branchTaken = 1; #1;
    assertions++;
    if (ctl !== 5'b00010) begin
      failures++; $display("FAIL stall_branch_c1_ctl: got %b expected 00010", ctl);
    end
    tick();
    stallBeq = 0; #1;
    assertions++;
    if (ctl !== 5'b11100) begin
      failures++; $display("FAIL stall_branch_c2_ctl: got %b expected 11100", ctl);
    end
    tick();
    setIdle();
    assertions++;
    if (flushCnt !== 16'd1 || stallCnt !== 16'd1) begin
      failures++; $display("FAIL stall_branch_cnts: flush=%0d stall=%0d expected 1 1", flushCnt, stallCnt);
    end
    jump = 1; stallLw = 1; stallBeq = 1; #1;
    assertions++;
    if (ctl !== 5'b00010) begin
      failures++; $display("FAIL dual_stall_jump_ctl: got %b expected 00010", ctl);
    end
    tick();
    stallLw = 0; stallBeq = 0; #1;
    tick();
    setIdle();
    assertions++;
    if (stallCnt !== 16'd2 || flushCnt !== 16'd2) begin
      failures++; $display("FAIL dual_stall_jump_cnts: stall=%0d flush=%0d expected 2 2", stallCnt, flushCnt);
    end
  endtask

  task automatic test_mem_freeze();
    resetAndBoot();
    dmemReq = 1; dmemReady = 0;
    for (int i = 0; i < 3; i++) begin
      stallLw = (i == 1); branchTaken = (i == 2); #1;
      assertions++;
      if (ctl !== 5'b00001) begin
        failures++; $display("FAIL freeze_c%0d_ctl: got %b expected 00001", i + 1, ctl);
      end
      tick();
    end
    dmemReady = 1; stallLw = 1; #1;
    assertions++;
    if (ctl !== 5'b11000) begin
      failures++; $display("FAIL freeze_release_ctl: got %b expected 11000", ctl);
    end
    tick();
    setIdle();
    branchTaken = 1; #1;
    assertions++;
    if (ctl !== 5'b11100) begin
      failures++; $display("FAIL freeze_held_redirect_ctl: got %b expected 11100", ctl);
    end
    assertions++;
    if (freezeCnt !== 16'd3 || stallCnt !== 16'd0 || flushCnt !== 16'd0) begin
      failures++;
      $display("FAIL freeze_cnts: freeze=%0d stall=%0d flush=%0d expected 3 0 0", freezeCnt, stallCnt, flushCnt);
    end
    tick();
    setIdle();
    assertions++;
    if (flushCnt !== 16'd1) begin
      failures++; $display("FAIL freeze_redirect_flush_cnt: got %0d expected 1", flushCnt);
    end
  endtask

  task automatic test_watchdog();
    resetAndBoot();
    stallLw = 1; #1;
    for (int i = 0; i < 63; i++) tick();
    dmemReq = 1; #1;
    assertions++;
    if (ctl !== 5'b00001) begin
      failures++; $display("FAIL wd_freeze_ctl: got %b expected 00001", ctl);
    end
    tick();
    stallLw = 0; dmemReady = 1; #1;
    tick();
    setIdle();
    stallLw = 1; #1;
    for (int i = 0; i < 64; i++) begin
      assertions++;
      if (hazardErr !== 1'b0) begin
        failures++; $display("FAIL wd_early_err_c%0d: got %b expected 0", i + 1, hazardErr);
      end
      tick();
    end
    stallLw = 0; #1;
    assertions++;
    if (hazardErr !== 1'b1) begin
      failures++; $display("FAIL wd_err_rise: got %b expected 1", hazardErr);
    end
    tick(); tick(); tick();
    assertions++;
    if (hazardErr !== 1'b1) begin
      failures++; $display("FAIL wd_err_sticky: got %b expected 1", hazardErr);
    end
    assertions++;
    if (stallCnt !== 16'd127 || stallCnt4 !== 4'd15 || freezeCnt !== 16'd1) begin
      failures++;
      $display("FAIL wd_cnts: stall=%0d stall4=%0d freeze=%0d expected 127 15 1", stallCnt, stallCnt4, freezeCnt);
    end
    rst = 1; #1;
    tick();
    rst = 0; #1;
    assertions++;
    if (hazardErr !== 1'b0) begin
      failures++; $display("FAIL wd_err_reset: got %b expected 0", hazardErr);
    end
  endtask

  task automatic test_saturation();
    resetAndBoot();
    stallLw = 1; #1;
    for (int i = 0; i < 20; i++) tick();
    setIdle();
    assertions++;
    if (stallCnt4 !== 4'd15) begin
      failures++; $display("FAIL sat_stall_cnt4: got %0d expected 15", stallCnt4);
    end
    assertions++;
    if (stallCnt !== 16'd20) begin
      failures++; $display("FAIL sat_stall_cnt16: got %0d expected 20", stallCnt);
    end
    dmemReq = 1; #1;
    tick();
    rst = 1; #1;
    assertions++;
    if (ctl !== 5'b00110) begin
      failures++; $display("FAIL rst_mid_freeze_ctl: got %b expected 00110", ctl);
    end
    tick();
    rst = 0; #1;
    assertions++;
    if (ctl !== 5'b00110) begin
      failures++; $display("FAIL post_rst_boot_ctl: got %b expected 00110", ctl);
    end
    assertions++;
    if (stallCnt !== 16'd0 || freezeCnt !== 16'd0 || stallCnt4 !== 4'd0 || freezeCnt4 !== 4'd0) begin
      failures++;
      $display("FAIL post_rst_cnts: stall=%0d freeze=%0d stall4=%0d freeze4=%0d expected all 0",
               stallCnt, freezeCnt, stallCnt4, freezeCnt4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    setIdle();
    #3;
    test_reset();
    test_boot();
    test_load_use();
    test_stall_branch();
    test_mem_freeze();
    test_watchdog();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
